// File: rtl/ty_stream_sequencer.sv
// ---------------------------------------------------------------------------
// ty_stream_sequencer
//
// Purpose:
//   Drives a kernel from a memory-mapped buffer and writes its results back.
//   Each run walks a work instance of size_cfg elements, nwi_cfg times. The
//   load side reads ld_data one cycle after ld_en and presents it on an AXI
//   style stream through a 2-entry skid buffer. The store side accepts the
//   kernel result stream and turns every accepted beat into a memory write.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   start                 one-cycle launch pulse (ignored unless IDLE)
//   size_cfg, nwi_cfg     elements per work instance / instance count
//   ld_en, ld_addr        memory read strobe and element index
//   ld_data               read data, valid the cycle after ld_en
//   m_tvalid/m_tdata/m_tready   stream to kernel
//   s_tvalid/s_tdata/s_tready   stream from kernel
//   st_we, st_addr, st_data     memory write port
//   wi_count              completed load work instances
//   done                  one-cycle completion pulse
//
// Build option:
//   TY_SIMSTALL_EN        when defined, a 16-bit LFSR randomly withholds
//                         load issue to mimic shell back-pressure.
// ---------------------------------------------------------------------------
module ty_stream_sequencer #(
    parameter int DATAW = 32,
    parameter int GVECT = 1,
    parameter int NIN   = 2,
    parameter int AW    = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        start,
    input  logic [AW:0]                 size_cfg,
    input  logic [15:0]                 nwi_cfg,
    output logic                        ld_en,
    output logic [AW-1:0]               ld_addr,
    input  logic [NIN*GVECT*DATAW-1:0]  ld_data,
    output logic                        m_tvalid,
    output logic [NIN*GVECT*DATAW-1:0]  m_tdata,
    input  logic                        m_tready,
    input  logic                        s_tvalid,
    input  logic [GVECT*DATAW-1:0]      s_tdata,
    output logic                        s_tready,
    output logic                        st_we,
    output logic [AW-1:0]               st_addr,
    output logic [GVECT*DATAW-1:0]      st_data,
    output logic [15:0]                 wi_count,
    output logic                        done
);

    localparam int MW = NIN * GVECT * DATAW;
    localparam int TW = AW + 17;
    localparam logic [AW:0]   STEP_W = (AW+1)'(GVECT);
    localparam logic [AW-1:0] STEP_A = AW'(GVECT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     size_q, size_d;
    logic [15:0]     nwi_q, nwi_d;
    logic [AW-1:0]   ld_idx_q, ld_idx_d;
    logic [15:0]     wi_count_q, wi_count_d;
    logic            pending_q, pending_d;
    logic [MW-1:0]   buf0_q, buf0_d;
    logic [MW-1:0]   buf1_q, buf1_d;
    logic [1:0]      count_q, count_d;
    logic [AW-1:0]   st_idx_q, st_idx_d;
    logic [TW-1:0]   st_cnt_q, st_cnt_d;
    logic [TW-1:0]   st_total_q, st_total_d;

    logic            start_ok;
    logic [AW:0]     cur_size;
    logic [15:0]     cur_nwi;
    logic [15:0]     cur_wi;
    logic [AW-1:0]   cur_idx;
    logic            ld_last_idx;
    logic            ld_last_beat;
    logic            pop;
    logic [2:0]      occ;
    logic            slot_free;
    logic            stall;
    logic            ld_req;
    logic            st_wrap;
    logic            st_last;

    assign start_ok = start && (size_cfg != '0) && (nwi_cfg != '0);

    // The first load is issued in the start cycle itself, before the
    // configuration is registered, so the load side looks at the live
    // config while IDLE and at the captured copy afterwards.
    assign cur_size = (state_q == IDLE) ? size_cfg : size_q;
    assign cur_nwi  = (state_q == IDLE) ? nwi_cfg  : nwi_q;
    assign cur_wi   = (state_q == IDLE) ? '0       : wi_count_q;
    assign cur_idx  = (state_q == IDLE) ? '0       : ld_idx_q;

    assign ld_last_idx  = ({1'b0, cur_idx} == (cur_size - STEP_W));
    assign ld_last_beat = ld_last_idx && (cur_wi == (cur_nwi - 16'd1));

    // A slot is free when buffered plus in-flight beats leave room, or when
    // the head beat leaves this cycle. This keeps full rate with m_tready
    // held high while never overrunning the two entries.
    assign pop       = (count_q != 2'd0) && m_tready;
    assign occ       = {1'b0, count_q} + {2'b00, pending_q};
    assign slot_free = (occ < 3'd2) || pop;

`ifdef TY_SIMSTALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Free-running Fibonacci LFSR; a zero low nibble withholds one load.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[3:0] == 4'h0);
`else
    assign stall = 1'b0;
`endif

    assign st_wrap = ({1'b0, st_idx_q} == (size_q - STEP_W));
    assign st_last = st_we && (st_cnt_q == (st_total_q - TW'(1)));

    // State register and all datapath flops.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            size_q     <= '0;
            nwi_q      <= '0;
            ld_idx_q   <= '0;
            wi_count_q <= '0;
            pending_q  <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
            st_idx_q   <= '0;
            st_cnt_q   <= '0;
            st_total_q <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            nwi_q      <= nwi_d;
            ld_idx_q   <= ld_idx_d;
            wi_count_q <= wi_count_d;
            pending_q  <= pending_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            st_idx_q   <= st_idx_d;
            st_cnt_q   <= st_cnt_d;
            st_total_q <= st_total_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ld_en && ld_last_beat) begin
                    state_d = DRAIN;
                end else if (start_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ld_en && ld_last_beat) begin
                    state_d = st_last ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (st_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ld_req   = 1'b0;
        s_tready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE:    ld_req = start_ok;
            RUN: begin
                ld_req   = 1'b1;
                s_tready = 1'b1;
            end
            DRAIN:   s_tready = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        ld_en = ld_req && slot_free && !stall;
    end

    // Load/store indices, counters and the skid buffer.
    always_comb begin
        size_d     = size_q;
        nwi_d      = nwi_q;
        ld_idx_d   = ld_idx_q;
        wi_count_d = wi_count_q;
        pending_d  = ld_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        count_d    = count_q;
        st_idx_d   = st_idx_q;
        st_cnt_d   = st_cnt_q;
        st_total_d = st_total_q;

        if ((state_q == IDLE) && start_ok) begin
            size_d     = size_cfg;
            nwi_d      = nwi_cfg;
            ld_idx_d   = '0;
            wi_count_d = '0;
            st_idx_d   = '0;
            st_cnt_d   = '0;
            st_total_d = (TW'(nwi_cfg) * TW'(size_cfg)) / TW'(GVECT);
        end

        if (ld_en) begin
            if (ld_last_idx) begin
                ld_idx_d   = '0;
                wi_count_d = cur_wi + 16'd1;
            end else begin
                ld_idx_d   = cur_idx + STEP_A;
            end
        end

        if (st_we) begin
            st_cnt_d = st_cnt_q + TW'(1);
            st_idx_d = st_wrap ? '0 : (st_idx_q + STEP_A);
        end

        // Returned read data always has a slot reserved for it.
        case ({pending_q, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = ld_data;
                end else begin
                    buf1_d = ld_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = ld_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ld_data;
                end
            end
            default: ;
        endcase
    end

    assign ld_addr  = cur_idx;
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = buf0_q;
    assign st_we    = s_tvalid && s_tready;
    assign st_addr  = st_idx_q;
    assign st_data  = s_tdata;
    assign wi_count = wi_count_q;

endmodule
